// File: rtl/seq_trig_pkg.sv
// Shared types for the multi-channel sequencer trigger.
// Holds the burst FSM states and MIDI channel helpers.
package seq_trig_pkg;

    localparam int MIDI_CH_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_SEND,
        ST_WAIT
    } burst_st_t;

    // Channel offset from the slot group base, wrapping mod 16.
    function automatic logic [MIDI_CH_W-1:0] ch_offset(
        input logic [MIDI_CH_W-1:0] ch,
        input logic [MIDI_CH_W-1:0] base
    );
        return ch - base;
    endfunction

endpackage

// File: rtl/pulse_dly.sv
// Trigger delay line with rising-edge detectors.
// o_early fires two cycles after i_d rises, o_pulse DEPTH cycles after.
module pulse_dly #(
    parameter int DEPTH = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_early,
    output logic o_pulse
);

    logic [DEPTH:0] r_dly;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dly <= '0;
        end else begin
            r_dly <= {r_dly[DEPTH-1:0], i_d};
        end
    end

    assign o_early = r_dly[1] & ~r_dly[2];
    assign o_pulse = r_dly[DEPTH-1] & ~r_dly[DEPTH];

endmodule

// File: rtl/seq_trigger_mc.sv
// Multi-channel sequencer trigger with note-stack delay
// and patch-send burst generator.
module seq_trigger_mc
    import seq_trig_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int NB_W      = 8,
    parameter int STACK_DLY = 3,
    parameter int SEND_GAP  = 4,
    parameter int PATCH_LEN = 128,
    parameter int SLOT_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 reg_clk,
    input  logic                 reset_reg_N,
    input  logic [MIDI_CH_W-1:0] ch_base,
    input  logic                 omni,
    input  logic [MIDI_CH_W-1:0] midi_ch,
    input  logic                 byteready,
    input  logic [NB_W-1:0]      midibyte_nr,
    input  logic [7:0]           midi_in_data,
    input  logic                 is_st_sysex,
    input  logic                 syx_cmd,
    input  logic                 dec_sysex_data_patch_send,
    input  logic                 auto_syx_cmd,
    output logic [SLOT_W-1:0]    cur_slot,
    output logic [NUM_CH-1:0]    slot_hit,
    output logic [NB_W-1:0]      midi_bytes,
    output logic [7:0]           seq_databyte,
    output logic                 is_data_byte,
    output logic                 is_velocity,
    output logic                 trig_seq,
    output logic                 trig_note_stack,
    output logic                 midi_send_byte,
    output logic                 syx_data_ready,
    output logic                 send_done,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(PATCH_LEN + 1);
    localparam int GAP_W = 8;

    logic [MIDI_CH_W-1:0] w_diff;
    logic                 w_in_range;
    logic                 w_accepted;
    logic                 w_acc;
    logic [SLOT_W-1:0]    w_slot;
    logic                 w_early;
    logic                 w_syx_rise;

    logic [SLOT_W-1:0]    r_cur_slot;
    logic [NUM_CH-1:0]    r_slot_hit;
    logic [NB_W-1:0]      r_midi_bytes;
    logic [7:0]           r_databyte;
    logic                 r_trig;
    logic                 r_overrun;
    logic [2:0]           r_syx_s;
    logic                 r_sdr;

    burst_st_t            r_state;
    burst_st_t            w_nxt;
    logic [GAP_W-1:0]     r_gap;
    logic [GAP_W-1:0]     w_gap_n;
    logic [CNT_W-1:0]     r_sent;
    logic [CNT_W-1:0]     w_sent_n;
    logic                 w_send;
    logic                 w_done;

    assign w_diff     = ch_offset(midi_ch, ch_base);
    assign w_in_range = ({1'b0, w_diff} < 5'(NUM_CH));
    assign w_accepted = omni | w_in_range;
    assign w_slot     = omni ? '0 : w_diff[SLOT_W-1:0];
    assign w_acc      = w_accepted | is_st_sysex;
    assign w_syx_rise = r_syx_s[1] & ~r_syx_s[2];

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_cur_slot   <= '0;
            r_slot_hit   <= '0;
            r_midi_bytes <= '0;
            r_databyte   <= '0;
            r_trig       <= 1'b0;
            r_overrun    <= 1'b0;
            r_syx_s      <= '0;
            r_sdr        <= 1'b0;
        end else begin
            r_midi_bytes <= w_acc ? midibyte_nr : '0;
            r_databyte   <= w_acc ? midi_in_data : '0;
            r_slot_hit   <= w_accepted ? (NUM_CH'(1) << w_slot) : '0;
            if (w_accepted) begin
                r_cur_slot <= w_slot;
            end
            // A send strobe colliding with a received byte still yields one trigger.
            r_trig       <= w_acc & (byteready | w_send);
            r_overrun    <= byteready & w_send;
            r_syx_s      <= {r_syx_s[1:0], syx_cmd};
            r_sdr        <= w_syx_rise |
                            ((dec_sysex_data_patch_send | auto_syx_cmd) & w_early);
        end
    end

    pulse_dly #(
        .DEPTH (STACK_DLY)
    ) u_dly (
        .i_clk   (reg_clk),
        .i_rst_n (reset_reg_N),
        .i_d     (r_trig),
        .o_early (w_early),
        .o_pulse (trig_note_stack)
    );

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_state <= ST_IDLE;
            r_gap   <= '0;
            r_sent  <= '0;
        end else begin
            r_state <= w_nxt;
            r_gap   <= w_gap_n;
            r_sent  <= w_sent_n;
        end
    end

    always_comb begin
        w_nxt    = r_state;
        w_gap_n  = r_gap;
        w_sent_n = r_sent;
        w_send   = 1'b0;
        w_done   = 1'b0;
        // Dropping patch-send aborts the burst and masks any pending strobe.
        if (r_state != ST_IDLE && !dec_sysex_data_patch_send) begin
            w_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (dec_sysex_data_patch_send && r_trig) begin
                        w_nxt    = ST_GAP;
                        w_gap_n  = GAP_W'(SEND_GAP - 1);
                        w_sent_n = '0;
                    end
                end
                ST_GAP: begin
                    if (r_gap == '0) begin
                        w_nxt = ST_SEND;
                    end else begin
                        w_gap_n = r_gap - GAP_W'(1);
                    end
                end
                ST_SEND: begin
                    w_send   = 1'b1;
                    w_sent_n = r_sent + CNT_W'(1);
                    if (w_sent_n == CNT_W'(PATCH_LEN)) begin
                        w_done = 1'b1;
                        w_nxt  = ST_IDLE;
                    end else begin
                        w_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_trig) begin
                        w_nxt   = ST_GAP;
                        w_gap_n = GAP_W'(SEND_GAP - 1);
                    end
                end
                default: w_nxt = ST_IDLE;
            endcase
        end
    end

    assign cur_slot       = r_cur_slot;
    assign slot_hit       = r_slot_hit;
    assign midi_bytes     = r_midi_bytes;
    assign seq_databyte   = r_databyte;
    assign is_data_byte   = r_midi_bytes[0];
    assign is_velocity    = ~r_midi_bytes[0] & (|r_midi_bytes);
    assign trig_seq       = r_trig;
    assign midi_send_byte = w_send;
    assign syx_data_ready = r_sdr;
    assign send_done      = w_done;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_seq_trigger_mc.sv
// Self-checking bench for seq_trigger_mc: directed scenarios
// plus random traffic against a cycle-level reference model.
module tb_seq_trigger_mc;

    localparam int NCH  = 4;
    localparam int NBW  = 8;
    localparam int SD   = 3;
    localparam int GAP  = 4;
    localparam int PLEN = 3;
    localparam int SW   = 2;

    logic           reg_clk = 1'b0;
    logic           reset_reg_N = 1'b0;
    logic [3:0]     ch_base = '0;
    logic           omni = 1'b0;
    logic [3:0]     midi_ch = '0;
    logic           byteready = 1'b0;
    logic [NBW-1:0] midibyte_nr = '0;
    logic [7:0]     midi_in_data = '0;
    logic           is_st_sysex = 1'b0;
    logic           syx_cmd = 1'b0;
    logic           patch = 1'b0;
    logic           auto_syx = 1'b0;

    logic [SW-1:0]  cur_slot;
    logic [NCH-1:0] slot_hit;
    logic [NBW-1:0] midi_bytes;
    logic [7:0]     seq_databyte;
    logic           is_data_byte, is_velocity, trig_seq, trig_note_stack;
    logic           midi_send_byte, syx_data_ready, send_done, overrun;

    seq_trigger_mc #(
        .NUM_CH(NCH), .NB_W(NBW), .STACK_DLY(SD),
        .SEND_GAP(GAP), .PATCH_LEN(PLEN)
    ) dut (
        .reg_clk(reg_clk), .reset_reg_N(reset_reg_N),
        .ch_base(ch_base), .omni(omni), .midi_ch(midi_ch),
        .byteready(byteready), .midibyte_nr(midibyte_nr),
        .midi_in_data(midi_in_data), .is_st_sysex(is_st_sysex),
        .syx_cmd(syx_cmd), .dec_sysex_data_patch_send(patch),
        .auto_syx_cmd(auto_syx), .cur_slot(cur_slot),
        .slot_hit(slot_hit), .midi_bytes(midi_bytes),
        .seq_databyte(seq_databyte), .is_data_byte(is_data_byte),
        .is_velocity(is_velocity), .trig_seq(trig_seq),
        .trig_note_stack(trig_note_stack),
        .midi_send_byte(midi_send_byte),
        .syx_data_ready(syx_data_ready), .send_done(send_done),
        .overrun(overrun)
    );

    always #5 reg_clk = ~reg_clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int       m_slot;
    bit [3:0] m_hit;
    bit [7:0] m_bytes, m_data;
    bit       m_trig, m_over, m_sdr;
    bit       m_busy, m_wait;
    int       m_cd, m_sent;
    bit       trig_h [1:6];
    bit       syx_h [1:4];
    bit       e_done;
    bit       obs_trig, obs_send, obs_done;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_slot = 0; m_hit = 0; m_bytes = 0; m_data = 0;
        m_trig = 0; m_over = 0; m_sdr = 0;
        m_busy = 0; m_wait = 0; m_cd = 0; m_sent = 0;
        for (int k = 1; k <= 6; k++) trig_h[k] = 0;
        for (int k = 1; k <= 4; k++) syx_h[k] = 0;
    endtask

    function automatic bit m_send_now();
        return m_busy && !m_wait && m_cd == 0 && patch;
    endfunction

    task automatic check_all();
        bit snd, dn;
        snd = m_send_now();
        dn = snd && (m_sent + 1 == PLEN);
        e_done = dn;
        chk("cur_slot", 32'(cur_slot), 32'(m_slot));
        chk("slot_hit", 32'(slot_hit), 32'(m_hit));
        chk("midi_bytes", 32'(midi_bytes), 32'(m_bytes));
        chk("seq_databyte", 32'(seq_databyte), 32'(m_data));
        chk("is_data_byte", 32'(is_data_byte), 32'(m_bytes[0]));
        chk("is_velocity", 32'(is_velocity),
            32'(!m_bytes[0] && m_bytes != 0));
        chk("trig_seq", 32'(trig_seq), 32'(m_trig));
        chk("trig_note_stack", 32'(trig_note_stack),
            32'(trig_h[SD] && !trig_h[SD+1]));
        chk("midi_send_byte", 32'(midi_send_byte), 32'(snd));
        chk("syx_data_ready", 32'(syx_data_ready), 32'(m_sdr));
        chk("send_done", 32'(send_done), 32'(dn));
        chk("overrun", 32'(overrun), 32'(m_over));
        obs_trig = trig_seq;
        obs_send = midi_send_byte;
        obs_done = send_done;
    endtask

    task automatic model_step();
        int diff, slot;
        bit accd, acc, snd, early, rise, ntrig, nover, nsdr;
        diff  = (int'(midi_ch) - int'(ch_base) + 16) % 16;
        accd  = omni || (diff < NCH);
        slot  = omni ? 0 : diff;
        acc   = accd || is_st_sysex;
        snd   = m_send_now();
        early = trig_h[2] && !trig_h[3];
        rise  = syx_h[2] && !syx_h[3];
        nsdr  = rise || ((patch || auto_syx) && early);
        ntrig = acc && (byteready || snd);
        nover = byteready && snd;
        if (m_busy && !patch) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (patch && m_trig) begin
                m_busy = 1; m_wait = 0; m_cd = GAP; m_sent = 0;
            end
        end else if (m_wait) begin
            if (m_trig) begin
                m_wait = 0; m_cd = GAP;
            end
        end else if (m_cd > 0) begin
            m_cd--;
        end else begin
            m_sent++;
            if (m_sent == PLEN) m_busy = 0;
            else m_wait = 1;
        end
        for (int k = 6; k >= 2; k--) trig_h[k] = trig_h[k-1];
        trig_h[1] = m_trig;
        for (int k = 4; k >= 2; k--) syx_h[k] = syx_h[k-1];
        syx_h[1] = syx_cmd;
        m_bytes = acc ? midibyte_nr : 8'd0;
        m_data  = acc ? midi_in_data : 8'd0;
        m_hit   = accd ? (4'd1 << slot) : 4'd0;
        if (accd) m_slot = slot;
        m_trig = ntrig;
        m_over = nover;
        m_sdr  = nsdr;
    endtask

    task automatic cyc();
        #1;
        check_all();
        model_step();
        @(negedge reg_clk);
    endtask

    task automatic idle(input int n);
        byteready = 0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        bit   trig_at [0:40];
        int   sc [0:7];
        int   nsend, ndone, done_cyc;
        bit   hit;

        model_reset();
        #3;
        chk("reset_state", {cur_slot, slot_hit, midi_bytes, seq_databyte,
            is_data_byte, is_velocity, trig_seq, trig_note_stack,
            midi_send_byte, syx_data_ready, send_done, overrun}, 0);
        @(negedge reg_clk);
        reset_reg_N = 1;
        idle(3);

        // Slot mapping with wrap-around
        ch_base = 4'd14; midi_ch = 4'd1; byteready = 1;
        midibyte_nr = 8'd1; midi_in_data = 8'h3c;
        cyc();
        byteready = 0;
        chk("map_slot", 32'(cur_slot), 3);
        chk("map_hit", 32'(slot_hit), 32'b1000);
        chk("map_trig", 32'(trig_seq), 1);
        midi_ch = 4'd2; byteready = 1;
        cyc();
        byteready = 0;
        chk("map_reject_trig", 32'(trig_seq), 0);
        chk("map_reject_hit", 32'(slot_hit), 0);
        idle(8);

        // Note-stack delay
        ch_base = 4'd0; midi_ch = 4'd1; byteready = 1;
        cyc();
        byteready = 0;
        chk("ns_trig_t1", 32'(trig_seq), 1);
        chk("ns_stack_t1", 32'(trig_note_stack), 0);
        cyc();
        chk("ns_stack_t2", 32'(trig_note_stack), 0);
        cyc();
        chk("ns_stack_t3", 32'(trig_note_stack), 0);
        cyc();
        chk("ns_stack_t4", 32'(trig_note_stack), 1);
        cyc();
        chk("ns_stack_t5", 32'(trig_note_stack), 0);
        idle(6);

        // Full burst
        midi_ch = 4'd9; is_st_sysex = 1; patch = 1;
        for (int i = 0; i <= 40; i++) trig_at[i] = 0;
        for (int i = 0; i < 8; i++) sc[i] = 0;
        nsend = 0; ndone = 0; done_cyc = -1;
        byteready = 1;
        cyc();
        byteready = 0;
        trig_at[0] = obs_trig;
        for (int n = 1; n <= 30; n++) begin
            cyc();
            trig_at[n] = obs_trig;
            if (obs_send) begin
                if (nsend < 8) sc[nsend] = n;
                nsend++;
            end
            if (obs_done) begin
                ndone++;
                done_cyc = n;
            end
            if (e_done) patch = 0;
        end
        chk("burst_sends", nsend, 3);
        chk("burst_dones", ndone, 1);
        chk("burst_first", sc[0], 6);
        chk("burst_done_cyc", done_cyc, sc[2]);
        for (int i = 0; i < 3; i++)
            chk("burst_gap", 32'((sc[i] >= 5) ? trig_at[sc[i]-5] : 1'b0), 1);
        idle(6);

        // Collision of received byte with send strobe
        patch = 1; byteready = 1;
        cyc();
        byteready = 0;
        hit = 0;
        for (int n = 0; n < 20 && !hit; n++) begin
            if (m_send_now()) hit = 1;
            else cyc();
        end
        chk("coll_reached", 32'(hit), 1);
        byteready = 1;
        cyc();
        byteready = 0;
        chk("coll_trig", 32'(trig_seq), 1);
        chk("coll_overrun", 32'(overrun), 1);
        cyc();
        chk("coll_trig_once", 32'(trig_seq), 0);
        chk("coll_overrun_end", 32'(overrun), 0);
        patch = 0;
        idle(8);

        // Abort in GAP
        patch = 1; byteready = 1;
        cyc();
        byteready = 0;
        cyc(); cyc(); cyc();
        patch = 0;
        nsend = 0; ndone = 0;
        for (int n = 0; n < 12; n++) begin
            cyc();
            if (obs_send) nsend++;
            if (obs_done) ndone++;
        end
        chk("abort_sends", nsend, 0);
        chk("abort_dones", ndone, 0);

        // Asynchronous reset in WAIT
        is_st_sysex = 0; ch_base = 4'd0; midi_ch = 4'd2;
        patch = 1; byteready = 1;
        cyc();
        byteready = 0; midi_ch = 4'd9;
        hit = 0;
        for (int n = 0; n < 20 && !hit; n++) begin
            cyc();
            if (m_busy && m_wait) hit = 1;
        end
        chk("wait_reached", 32'(hit), 1);
        cyc(); cyc();
        chk("wait_slot", 32'(cur_slot), 2);
        #2 reset_reg_N = 0;
        #1;
        chk("rst_async", {cur_slot, slot_hit, midi_bytes, seq_databyte,
            is_data_byte, is_velocity, trig_seq, trig_note_stack,
            midi_send_byte, syx_data_ready, send_done, overrun}, 0);
        @(negedge reg_clk);
        @(negedge reg_clk);
        reset_reg_N = 1;
        model_reset();
        idle(10);
        patch = 0;
        idle(4);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            byteready    = ($urandom_range(0, 2) == 0);
            midibyte_nr  = 8'($urandom);
            midi_in_data = 8'($urandom);
            midi_ch      = 4'($urandom);
            if ($urandom_range(0, 7) == 0) ch_base = 4'($urandom);
            omni         = ($urandom_range(0, 9) == 0);
            is_st_sysex  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) patch = ~patch;
            if ($urandom_range(0, 15) == 0) auto_syx = ~auto_syx;
            if ($urandom_range(0, 7) == 0) syx_cmd = ~syx_cmd;
            cyc();
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
